// File: rtl/spi_accel_burst_reader_if.sv
// ---------------------------------------------------------------------------
// spi_accel_burst_reader_if
// Bundles the accelerometer SPI pins and the sample-publish bus of
// spi_accel_burst_reader.
//   enable     : run control into the reader
//   MISO       : serial data from sensor
//   SCLK/MOSI/CS : SPI mode 0 pins driven by the reader
//   busy       : burst (or inter-burst gap) in progress
//   axis_data  : NUM_AXES sign-extended samples, axis k at [k*OUT_WIDTH +: OUT_WIDTH]
//   data_valid : one-clk strobe when axis_data updates
// The "master" modport is the reader (SPI master) side; "slave" is the
// sensor/consumer side.
// ---------------------------------------------------------------------------
interface spi_accel_burst_reader_if #(
    parameter int NUM_AXES  = 3,
    parameter int OUT_WIDTH = 16
);
    logic                          enable;
    logic                          MISO;
    logic                          SCLK;
    logic                          MOSI;
    logic                          CS;
    logic                          busy;
    logic [NUM_AXES*OUT_WIDTH-1:0] axis_data;
    logic                          data_valid;

    modport master (
        input  enable, MISO,
        output SCLK, MOSI, CS, busy, axis_data, data_valid
    );

    modport slave (
        output enable, MISO,
        input  SCLK, MOSI, CS, busy, axis_data, data_valid
    );
endinterface

// File: rtl/spi_accel_burst_reader.sv
// ---------------------------------------------------------------------------
// spi_accel_burst_reader
// SPI mode-0 master that periodically burst-reads NUM_AXES consecutive
// little-endian 16-bit axis registers in one CS-low transaction, reduces each
// word to SAMPLE_WIDTH bits, sign-extends to OUT_WIDTH and publishes the whole
// set atomically with a one-clk data_valid strobe.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : spi_accel_burst_reader_if.master (enable, MISO, SCLK, MOSI, CS,
//            busy, axis_data, data_valid)
// Burst period with enable held: 1 + CLK_DIV*(2 + 2N) + GAP_CYCLES clks,
// N = 16 + 16*NUM_AXES.
// ---------------------------------------------------------------------------
module spi_accel_burst_reader #(
    parameter int         CLK_DIV      = 32,
    parameter int         NUM_AXES     = 3,
    parameter logic [7:0] READ_CMD     = 8'h0B,
    parameter logic [7:0] START_ADDR   = 8'h0E,
    parameter int         SAMPLE_WIDTH = 12,
    parameter int         OUT_WIDTH    = 16,
    parameter int         GAP_CYCLES   = 64
) (
    input logic                      clk,
    input logic                      resetn,
    spi_accel_burst_reader_if.master bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    localparam int N_BITS  = 16 + 16 * NUM_AXES;
    localparam int BIT_W   = $clog2(N_BITS);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SHAMT   = 16 - SAMPLE_WIDTH;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
    localparam logic [15:0]      TX_WORD  = {READ_CMD, START_ADDR};

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [BIT_W-1:0]                     bit_q, bit_d;
    logic                                 sclk_q, sclk_d;
    logic                                 cs_q, cs_d;
    logic                                 mosi_q, mosi_d;
    logic                                 busy_q, busy_d;
    logic                                 data_valid_q, data_valid_d;
    logic [7:0]                           rx_q, rx_d;
    logic [7:0]                           lo_q, lo_d;
    logic [NUM_AXES-1:0][OUT_WIDTH-1:0]   shadow_q, shadow_d;
    logic [NUM_AXES-1:0][OUT_WIDTH-1:0]   axis_data_q, axis_data_d;

    logic [7:0]       rx_next;
    logic             samp_en;
    logic [BIT_W-1:0] samp_bit;

    // Command/address bits go out MSB first; everything after bit 15 is 0.
    function automatic logic tx_bit(input logic [BIT_W-1:0] b);
        logic [3:0] idx;
        idx = 4'd15 - b[3:0];
        return (b < BIT_W'(16)) ? TX_WORD[idx] : 1'b0;
    endfunction

    // Keep the low SAMPLE_WIDTH bits: shift them to the top, shift back
    // arithmetically, then widen with sign.
    function automatic logic [OUT_WIDTH-1:0] sext(input logic [15:0] w);
        logic signed [15:0] t;
        t = $signed(w << SHAMT) >>> SHAMT;
        return OUT_WIDTH'(t);
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        cs_d         = cs_q;
        mosi_d       = mosi_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        rx_d         = rx_q;
        lo_d         = lo_q;
        shadow_d     = shadow_q;
        axis_data_d  = axis_data_q;
        rx_next      = {rx_q[6:0], bus.MISO};
        samp_en      = 1'b0;
        samp_bit     = bit_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = TX_WORD[15];
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    sclk_d   = 1'b1;
                    samp_en  = 1'b1;
                    samp_bit = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // falling edge: present the next MOSI bit
                        sclk_d = 1'b0;
                        mosi_d = (bit_q == BIT_LAST) ? 1'b0 : tx_bit(bit_q + 1'b1);
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        // rising edge: sample MISO for the new bit
                        sclk_d   = 1'b1;
                        bit_d    = bit_q + 1'b1;
                        samp_en  = 1'b1;
                        samp_bit = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d      = GAP;
                    cnt_d        = '0;
                    cs_d         = 1'b1;
                    mosi_d       = 1'b0;
                    data_valid_d = 1'b1;
                    axis_data_d  = shadow_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte boundaries: even data byte is an axis low byte (parked in
        // lo), odd byte completes the word for axis (bit/16 - 1).
        if (samp_en) begin
            rx_d = rx_next;
            if (samp_bit[2:0] == 3'd7 && samp_bit >= BIT_W'(16)) begin
                if (!samp_bit[3]) begin
                    lo_d = rx_next;
                end else begin
                    for (int k = 0; k < NUM_AXES; k++) begin
                        if (int'(samp_bit >> 4) - 1 == k)
                            shadow_d[k] = sext({rx_next, lo_q});
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            rx_q         <= '0;
            lo_q         <= '0;
            shadow_q     <= '0;
            axis_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
            rx_q         <= rx_d;
            lo_q         <= lo_d;
            shadow_q     <= shadow_d;
            axis_data_q  <= axis_data_d;
        end
    end

    assign bus.SCLK       = sclk_q;
    assign bus.MOSI       = mosi_q;
    assign bus.CS         = cs_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = data_valid_q;
    assign bus.axis_data  = axis_data_q;

endmodule

// File: tb/tb_spi_accel_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_accel_burst_reader
// Three readers share one clock: A (CLK_DIV=4, 3 axes, 12-bit samples),
// B (same but 16-bit samples) and C (CLK_DIV=2, 1 axis). A single negedge
// process plays the sensor for all three and records SPI/strobe statistics.
// ---------------------------------------------------------------------------
module tb_spi_accel_burst_reader;

    logic clk = 1'b0;
    logic resetn_a, resetn_bc;
    always #5 clk = ~clk;

    spi_accel_burst_reader_if #(.NUM_AXES(3), .OUT_WIDTH(16)) ifa ();
    spi_accel_burst_reader_if #(.NUM_AXES(3), .OUT_WIDTH(16)) ifb ();
    spi_accel_burst_reader_if #(.NUM_AXES(1), .OUT_WIDTH(16)) ifc ();

    spi_accel_burst_reader #(.CLK_DIV(4), .NUM_AXES(3), .SAMPLE_WIDTH(12),
        .OUT_WIDTH(16), .GAP_CYCLES(64)) dut_a (.clk(clk), .resetn(resetn_a), .bus(ifa.master));
    spi_accel_burst_reader #(.CLK_DIV(4), .NUM_AXES(3), .SAMPLE_WIDTH(16),
        .OUT_WIDTH(16), .GAP_CYCLES(64)) dut_b (.clk(clk), .resetn(resetn_bc), .bus(ifb.master));
    spi_accel_burst_reader #(.CLK_DIV(2), .NUM_AXES(1), .SAMPLE_WIDTH(12),
        .OUT_WIDTH(16), .GAP_CYCLES(64)) dut_c (.clk(clk), .resetn(resetn_bc), .bus(ifc.master));

    int applied = 0;
    int fails   = 0;
    int cyc     = 0;

    logic [7:0] bytes [3][8];
    int   fcnt[3], rise[3], cslow[3], last_cslow[3], csfall[3];
    int   vcnt[3], vtime[3], tail1[3], dvrun[3], dvmax[3];
    logic [15:0] mosi_sr[3];
    logic prev_cs[3]   = '{1'b1, 1'b1, 1'b1};
    logic prev_sclk[3] = '{1'b0, 1'b0, 1'b0};
    logic cs_s[3], sclk_s[3], mosi_s[3], dv_s[3], miso_s[3];

    function automatic logic miso_bit(input int d, input int c);
        int o;
        logic [7:0] b;
        if (c < 16) return 1'b0;
        o = c - 16;
        if (o / 8 >= 8) return 1'b0;
        b = bytes[d][o / 8];
        return b[7 - (o % 8)];
    endfunction

    // Sensor model + monitor: MISO changes half a clk after SCLK falls (or
    // CS falls), MOSI is captured while SCLK is high.
    always @(negedge clk) begin
        cyc++;
        cs_s   = '{ifa.CS, ifb.CS, ifc.CS};
        sclk_s = '{ifa.SCLK, ifb.SCLK, ifc.SCLK};
        mosi_s = '{ifa.MOSI, ifb.MOSI, ifc.MOSI};
        dv_s   = '{ifa.data_valid, ifb.data_valid, ifc.data_valid};
        for (int d = 0; d < 3; d++) begin
            if (cs_s[d]) begin
                if (!prev_cs[d]) last_cslow[d] = cslow[d];
                cslow[d] = 0;
                fcnt[d]  = 0;
            end else begin
                if (prev_cs[d]) begin
                    csfall[d]++;
                    rise[d]    = 0;
                    mosi_sr[d] = '0;
                    tail1[d]   = 0;
                end
                cslow[d]++;
                if (sclk_s[d] && !prev_sclk[d]) begin
                    if (rise[d] < 16) mosi_sr[d] = {mosi_sr[d][14:0], mosi_s[d]};
                    else if (mosi_s[d]) tail1[d]++;
                    rise[d]++;
                end
                if (!sclk_s[d] && prev_sclk[d]) fcnt[d]++;
            end
            if (dv_s[d]) begin
                vcnt[d]++;
                vtime[d] = cyc;
                dvrun[d]++;
                if (dvrun[d] > dvmax[d]) dvmax[d] = dvrun[d];
            end else begin
                dvrun[d] = 0;
            end
            miso_s[d]    = miso_bit(d, fcnt[d]);
            prev_cs[d]   = cs_s[d];
            prev_sclk[d] = sclk_s[d];
        end
        ifa.MISO = miso_s[0];
        ifb.MISO = miso_s[1];
        ifc.MISO = miso_s[2];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // sample point: just after the monitor has run on the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [47:0] s);
        for (int k = 0; k < 8; k++) begin
            if (k < 6) bytes[d][k] = s[47 - 8 * k -: 8];
            else       bytes[d][k] = 8'h00;
        end
    endtask

    task automatic wait_valid(input int d, input int target, input int budget, input string nm);
        int n = 0;
        while (vcnt[d] < target && n < budget) begin step(); n++; end
        chk(nm, 64'(vcnt[d] >= target), 64'd1);
    endtask

    task automatic wait_bit(input int d, input int cf, input int bitn, input int budget, input string nm);
        int n = 0;
        while (!(csfall[d] > cf && rise[d] >= bitn) && n < budget) begin step(); n++; end
        chk(nm, 64'(csfall[d] > cf && rise[d] >= bitn), 64'd1);
    endtask

    typedef struct packed {
        logic [47:0] stream;   // bytes in wire order, first byte in [47:40]
        logic [47:0] expd;     // {axis2, axis1, axis0}
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n0, cf, t1, t2, t3;
        logic [47:0] ev;

        vecs[0] = {48'h3402_FF0F_0008, 48'hF800_FFFF_0234};
        vecs[1] = {48'h34F2_FF0F_0008, 48'hF800_FFFF_0234};  // garbage upper nibbles
        vecs[2] = {48'hFF07_01F8_0000, 48'h0000_F801_07FF};
        vecs[3] = {48'h0008_FFA7_55A5, 48'h0555_07FF_F800};
        vecs[4] = {48'h0100_FE0F_0007, 48'h0700_FFFE_0001};

        resetn_a = 1'b0; resetn_bc = 1'b0;
        ifa.enable = 1'b0; ifb.enable = 1'b0; ifc.enable = 1'b0;
        for (int d = 0; d < 3; d++) load(d, 48'h0);
        repeat (3) step();

        chk("rst_cs",   ifa.CS, 1);
        chk("rst_sclk", ifa.SCLK, 0);
        chk("rst_mosi", ifa.MOSI, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_dv",   ifa.data_valid, 0);
        chk("rst_axis", ifa.axis_data, 0);

        resetn_a = 1'b1; resetn_bc = 1'b1;
        repeat (3) step();
        chk("idle_cs", ifa.CS, 1);

        // single bursts, one per vector
        for (int i = 0; i < 5; i++) begin
            load(0, vecs[i].stream);
            n0 = vcnt[0];
            ifa.enable = 1'b1;
            repeat (3) step();
            ifa.enable = 1'b0;
            wait_valid(0, n0 + 1, 2000, $sformatf("v%0d_valid", i));
            repeat (70) step();
            ev = vecs[i].expd;
            for (int k = 0; k < 3; k++)
                chk($sformatf("v%0d_axis%0d", i, k), ifa.axis_data[k*16 +: 16], ev[k*16 +: 16]);
            if (i == 0) begin
                chk("cmd_addr_mosi", mosi_sr[0], 16'h0B0E);
                chk("mosi_tail_zero", tail1[0], 0);
                chk("sclk_rises", rise[0], 64);
                chk("cs_low_clks", last_cslow[0], 520);
                chk("one_pulse", vcnt[0], n0 + 1);
                chk("idle_busy", ifa.busy, 0);
            end
        end

        // back-to-back bursts, then drop enable at bit 20 of the fourth
        load(0, vecs[0].stream);
        n0 = vcnt[0];
        ifa.enable = 1'b1;
        wait_valid(0, n0 + 1, 2000, "cont_v1"); t1 = vtime[0];
        wait_valid(0, n0 + 2, 2000, "cont_v2"); t2 = vtime[0];
        wait_valid(0, n0 + 3, 2000, "cont_v3"); t3 = vtime[0];
        chk("period_1_2", t2 - t1, 585);
        chk("period_2_3", t3 - t2, 585);
        cf = csfall[0];
        wait_bit(0, cf, 21, 2000, "reach_bit20");
        ifa.enable = 1'b0;
        wait_valid(0, n0 + 4, 2000, "drop_valid");
        chk("period_3_4", vtime[0] - t3, 585);
        repeat (200) step();
        chk("drop_cs_high", ifa.CS, 1);
        chk("drop_busy", ifa.busy, 0);
        chk("drop_no_restart", csfall[0], cf + 1);
        chk("drop_axis", ifa.axis_data, vecs[0].expd);

        // reset in the middle of a burst
        load(0, vecs[3].stream);
        ifa.enable = 1'b1;
        cf = csfall[0];
        wait_bit(0, cf, 41, 2000, "reach_bit40");
        n0 = vcnt[0];
        @(posedge clk); #2;
        resetn_a = 1'b0;
        #1;
        chk("midrst_cs", ifa.CS, 1);
        chk("midrst_sclk", ifa.SCLK, 0);
        chk("midrst_axis", ifa.axis_data, 0);
        chk("midrst_busy", ifa.busy, 0);
        repeat (3) step();
        chk("midrst_no_dv", vcnt[0], n0);
        cf = csfall[0];
        resetn_a = 1'b1;
        wait_bit(0, cf, 1, 50, "restart_cs");
        ifa.enable = 1'b0;
        wait_valid(0, n0 + 1, 2000, "restart_valid");
        chk("restart_mosi", mosi_sr[0], 16'h0B0E);
        chk("restart_rises", rise[0], 64);
        chk("restart_axis", ifa.axis_data, vecs[3].expd);

        // 16-bit samples keep the upper nibble
        load(1, 48'h34F2_FF0F_0008);
        ifb.enable = 1'b1;
        repeat (3) step();
        ifb.enable = 1'b0;
        wait_valid(1, 1, 2000, "b_valid");
        chk("b_axis0", ifb.axis_data[15:0], 16'hF234);
        chk("b_axis1", ifb.axis_data[31:16], 16'h0FFF);
        chk("b_axis2", ifb.axis_data[47:32], 16'h0800);

        // single axis, CLK_DIV=2
        load(2, 48'hFF07_0000_0000);
        ifc.enable = 1'b1;
        wait_valid(2, 1, 1000, "c_valid1"); t1 = vtime[2];
        wait_valid(2, 2, 1000, "c_valid2");
        ifc.enable = 1'b0;
        chk("c_period", vtime[2] - t1, 197);
        chk("c_axis0", ifc.axis_data, 16'h07FF);
        chk("c_rises", rise[2], 32);
        chk("c_cs_low", last_cslow[2], 132);

        for (int d = 0; d < 3; d++)
            chk($sformatf("dv_width%0d", d), dvmax[d], 1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule

// File: doc/spi_accel_burst_reader.md
Name: spi_accel_burst_reader

Overview:
Parametrised SPI master that periodically burst-reads NUM_AXES consecutive 16-bit little-endian axis registers from an ADXL362-class accelerometer in one CS-low transaction. Each raw word is reduced to SAMPLE_WIDTH bits, sign-extended to OUT_WIDTH, and the whole sample set is published atomically with a one-cycle valid strobe. Sits between the board SPI pins and the display/processing logic; replaces the fixed-function per-register reader with a divider-, axis- and width-configurable block.

Parameters:
CLK_DIV, 32, clk cycles per SCLK half-period (>=2)
NUM_AXES, 3, axis words read per burst (1..4)
READ_CMD, 8'h0B, command byte sent first
START_ADDR, 8'h0E, register address sent second (low byte of first axis)
SAMPLE_WIDTH, 12, significant bits per axis word (<=16)
OUT_WIDTH, 16, output width per axis after sign extension (>=SAMPLE_WIDTH)
GAP_CYCLES, 64, clk cycles CS stays high between bursts (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
enable  input  1  1 = run bursts back to back; 0 = stop after current burst
MISO  input  1  serial data from sensor
SCLK  output  1  SPI clock, mode 0 (idle low)
MOSI  output  1  serial data to sensor, MSB first
CS  output  1  chip select, active low
busy  output  1  high from CS fall through end of GAP
axis_data  output  NUM_AXES*OUT_WIDTH  axis k in bits [k*OUT_WIDTH +: OUT_WIDTH], axis 0 = first word read
data_valid  output  1  one-clk pulse when axis_data updates

Behaviour:
- Reset (async, resetn=0): CS=1, SCLK=0, MOSI=0, busy=0, data_valid=0, axis_data=0, FSM=IDLE, divider and bit counters 0. Takes effect immediately, including mid-burst; the partial burst is discarded, axis_data not updated.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: CS=1, SCLK=0. If enable=1 at a clk edge -> SETUP next cycle (CS falls 1 clk after enable sampled high).
- SETUP: CS=0, MOSI=READ_CMD[7], SCLK=0 for CLK_DIV clks -> SHIFT.
- SHIFT: total bits N = 16 + 16*NUM_AXES. Per bit: SCLK high CLK_DIV clks then low CLK_DIV clks. MISO sampled on the clk where SCLK rises; MOSI updated on the clk where SCLK falls to the next bit. Bits 0-7 = READ_CMD, 8-15 = START_ADDR, bits 16..N-1 MOSI=0. After falling edge of bit N-1 -> HOLD.
- Receive: bytes assembled MSB first; byte 2j is low byte, byte 2j+1 high byte of axis j. Word = {high,low}; sample = word[SAMPLE_WIDTH-1:0]; output = sign extension of sample to OUT_WIDTH. Bits above SAMPLE_WIDTH in high byte ignored. Samples collected in a shadow register, never in axis_data directly.
- HOLD: CS=0, SCLK=0 for CLK_DIV clks; at end CS=1, shadow copied to axis_data, data_valid=1 for exactly that clk -> GAP.
- GAP: CS=1 for GAP_CYCLES clks, busy=1 -> IDLE; if enable still 1, immediately restarts (IDLE occupies 1 clk).
- enable falling mid-burst: burst completes normally, including data_valid; no new burst.
- enable toggled during GAP: only the value sampled in IDLE matters.
- busy=1 in SETUP, SHIFT, HOLD, GAP; 0 in IDLE.
- Burst period with enable held: 1 + CLK_DIV*(2 + 2N) + GAP_CYCLES clks.
- SCLK, CS, MOSI are registered outputs (no combinational paths from clk or counters).

Test Plan:
- CLK_DIV=4, NUM_AXES=3, enable=1: MOSI over bits 0-15 = 0x0B then 0x0E; 64 SCLK rising edges per CS-low window, SCLK period 8 clks, CS low for 4*(2+128)=520 clks.
- Slave model returns 0x34,0x02,0xFF,0x0F,0x00,0x08 -> single data_valid pulse; axis 0=0x0234, axis 1=0xFFFF, axis 2=0xF800.
- Same stream with high bytes 0xF2 (upper nibble garbage) -> axis 0 still 0x0234; SAMPLE_WIDTH=16 run -> axis 0=0xF234.
- enable held 1 for three bursts -> data_valid pulses exactly 585 clks apart (1+520+64); enable dropped at bit 20 -> that burst completes, valid pulses, CS stays high afterwards, busy=0.
- resetn pulsed low at bit 40 -> CS=1, SCLK=0 within the reset cycle, axis_data=0, no data_valid; after release with enable=1 a fresh burst starts from bit 0 with MOSI=0x0B.
- NUM_AXES=1, CLK_DIV=2: 32 SCLK edges, bytes 0xFF,0x07 -> axis 0=0x07FF, period 1+2*(2+64)+64=197 clks.
